// File: rtl/msc_pkg.sv
// msc_multi shared types: per-port FSM states and control/status bit positions.
// Status readback is built only with MSC_STATUS_READ_EN.
package msc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_FWAIT,
    ST_SWAP,
    ST_RESET,
    ST_RWAIT
  } msc_state_e;

  localparam int CTL_RESET = 0;
  localparam int CTL_FLUSH = 1;
  localparam int CTL_AUTO  = 2;
  localparam int CTL_EN    = 3;

  localparam int STS_ACT  = 0;
  localparam int STS_PEND = 1;
  localparam int STS_ERR  = 2;
  localparam int STS_AUTO = 3;

endpackage

// File: rtl/msc_multi_if.sv
// msc_multi register bus and cache-port bundle.
// master = CPU decode / cache side, slave = msc_multi.
interface msc_multi_if #(
  parameter int NUM_PORTS = 2,
  parameter int PAGE_W    = 7,
  parameter int AW        = $clog2(NUM_PORTS) + 1
);
  logic                        wren;
  logic                        ren;
  logic [AW-1:0]               A;
  logic [7:0]                  din;
  logic [7:0]                  dout;
  logic [NUM_PORTS*PAGE_W-1:0] page;
  logic [NUM_PORTS-1:0]        port_reset;
  logic [NUM_PORTS-1:0]        port_flush;
  logic [NUM_PORTS-1:0]        port_req;
  logic [NUM_PORTS-1:0]        port_ready;
  logic [NUM_PORTS-1:0]        port_busy;
  logic                        active;

  modport master (
    output wren, ren, A, din,
    output port_req, port_ready, port_busy,
    input  dout, page, port_reset,
    input  port_flush, active
  );

  modport slave (
    input  wren, ren, A, din,
    input  port_req, port_ready, port_busy,
    output dout, page, port_reset,
    output port_flush, active
  );
endinterface

// File: rtl/msc_port_fsm.sv
// One cache port: page/AUTO registers and the drain/flush/swap/reset sequencer.
// ERR bit exists only with MSC_STATUS_READ_EN.
module msc_port_fsm
  import msc_pkg::*;
#(
  parameter int PAGE_W     = 7,
  parameter bit FLUSH_EN   = 1'b1,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              ctl_we_i,
  input  logic              pg_we_i,
  input  logic [7:0]        din_i,
  input  logic              stat_rd_i,
  input  logic              port_req_i,
  input  logic              port_ready_i,
  input  logic              port_busy_i,
  output logic [PAGE_W-1:0] page_o,
  output logic              port_reset_o,
  output logic              port_flush_o,
  output logic              active_o,
  output logic [7:0]        status_o
);
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  msc_state_e        state_q, state_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [PAGE_W-1:0] pend_q, pend_d;
  logic              pvld_q, pvld_d;
  logic              auto_q, auto_d;
  logic              dofl_q, dofl_d;
  logic              dosw_q, dosw_d;
  logic              dors_q, dors_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              idle, ctl_en, cmd_fl, cmd_rs;
  logic              cmd_go, err_ev, err, drained;
  logic              unused_din;

  assign idle    = (state_q == ST_IDLE);
  assign ctl_en  = ctl_we_i & din_i[CTL_EN];
  assign cmd_fl  = din_i[CTL_FLUSH] & FLUSH_EN;
  assign cmd_rs  = din_i[CTL_RESET];
  assign cmd_go  = ctl_en & (cmd_fl | cmd_rs);
  assign err_ev  = (cmd_go | pg_we_i) & ~idle;
  assign drained = ~(port_req_i & ~port_ready_i);
  assign unused_din = ^din_i;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    auto_d  = auto_q;
    dofl_d  = dofl_q;
    dosw_d  = dosw_q;
    dors_d  = dors_q;
    cnt_d   = '0;
    if (ctl_en) auto_d = din_i[CTL_AUTO];
    unique case (state_q)
      ST_IDLE: begin
        if (pg_we_i) begin
          pend_d  = din_i[PAGE_W-1:0];
          pvld_d  = 1'b1;
          dosw_d  = 1'b1;
          dofl_d  = auto_q & FLUSH_EN;
          dors_d  = auto_q;
          state_d = ST_DRAIN;
        end else if (cmd_go) begin
          dosw_d  = 1'b0;
          dofl_d  = cmd_fl;
          dors_d  = cmd_rs;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          if (dofl_q)      state_d = ST_FLUSH;
          else if (dosw_q) state_d = ST_SWAP;
          else if (dors_q) state_d = ST_RESET;
          else             state_d = ST_IDLE;
        end
      end
      ST_FLUSH: state_d = ST_FWAIT;
      ST_FWAIT: begin
        if (!port_busy_i) begin
          if (dosw_q)      state_d = ST_SWAP;
          else if (dors_q) state_d = ST_RESET;
          else             state_d = ST_IDLE;
        end
      end
      ST_SWAP: begin
        page_d  = pend_q;
        pvld_d  = 1'b0;
        state_d = dors_q ? ST_RESET : ST_IDLE;
      end
      ST_RESET: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(RST_CYCLES - 1))
          state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (!port_busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      page_q  <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      auto_q  <= 1'b0;
      dofl_q  <= 1'b0;
      dosw_q  <= 1'b0;
      dors_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      auto_q  <= auto_d;
      dofl_q  <= dofl_d;
      dosw_q  <= dosw_d;
      dors_q  <= dors_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MSC_STATUS_READ_EN
  logic err_q, err_d;

  // a fault in the same cycle as the clearing read wins
  always_comb begin
    err_d = err_q;
    if (stat_rd_i) err_d = 1'b0;
    if (err_ev)    err_d = 1'b1;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_rd;
  assign unused_rd = stat_rd_i ^ err_ev;
  assign err = 1'b0;
`endif

  always_comb begin
    status_o           = '0;
    status_o[STS_ACT]  = ~idle;
    status_o[STS_PEND] = pvld_q;
    status_o[STS_ERR]  = err;
    status_o[STS_AUTO] = auto_q;
  end

  assign page_o       = page_q;
  assign port_reset_o = (state_q == ST_RESET);
  assign port_flush_o = (state_q == ST_FLUSH);
  assign active_o     = ~idle;

endmodule

// File: rtl/msc_multi.sv
// Memory subsystem control: address decode, per-port sequencers, read mux.
// Define MSC_STATUS_READ_EN to enable register readback.
module msc_multi
  import msc_pkg::*;
#(
  parameter int         NUM_PORTS  = 2,
  parameter int         PAGE_W     = 7,
  parameter logic [7:0] FLUSH_MASK = 8'b10,
  parameter int         RST_CYCLES = 2,
  parameter int         AW         = $clog2(NUM_PORTS) + 1
) (
  input logic        clk_sys,
  input logic        rst,
  msc_multi_if.slave bus
);
  logic [NUM_PORTS-1:0][PAGE_W-1:0] pg;
  logic [NUM_PORTS-1:0][7:0]        sts;
  logic [NUM_PORTS-1:0]             act;
  logic [NUM_PORTS-1:0]             prst;
  logic [NUM_PORTS-1:0]             pfl;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic ctl_sel, pg_sel;

    assign ctl_sel = (bus.A == AW'(2 * k));
    assign pg_sel  = (bus.A == AW'(2 * k + 1));

    msc_port_fsm #(
      .PAGE_W     (PAGE_W),
      .FLUSH_EN   (FLUSH_MASK[k]),
      .RST_CYCLES (RST_CYCLES)
    ) u_fsm (
      .clk_sys      (clk_sys),
      .rst          (rst),
      .ctl_we_i     (bus.wren & ctl_sel),
      .pg_we_i      (bus.wren & pg_sel),
      .din_i        (bus.din),
      .stat_rd_i    (bus.ren & ctl_sel),
      .port_req_i   (bus.port_req[k]),
      .port_ready_i (bus.port_ready[k]),
      .port_busy_i  (bus.port_busy[k]),
      .page_o       (pg[k]),
      .port_reset_o (prst[k]),
      .port_flush_o (pfl[k]),
      .active_o     (act[k]),
      .status_o     (sts[k])
    );
  end

  assign bus.page       = pg;
  assign bus.port_reset = prst;
  assign bus.port_flush = pfl;
  assign bus.active     = |act;

`ifdef MSC_STATUS_READ_EN
  logic [7:0] dout_q, dout_d;
  logic [7:0] rd_v;

  always_comb begin
    rd_v = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (bus.A == AW'(2 * k))     rd_v = sts[k];
      if (bus.A == AW'(2 * k + 1)) rd_v = 8'(pg[k]);
    end
  end

  assign dout_d = bus.ren ? rd_v : dout_q;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`else
  logic unused_rd;
  assign unused_rd = bus.ren ^ (^sts);
  assign bus.dout  = '0;
`endif

endmodule

// File: tb/tb_msc_multi.sv
// Scoreboarded directed bench for msc_multi (2 ports, PAGE_W=7, mask 'b10).
// Status-read checks follow MSC_STATUS_READ_EN.
module tb_msc_multi;
  logic clk_sys = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  msc_multi_if #(.NUM_PORTS(2), .PAGE_W(7)) bus ();

  msc_multi dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // sel: 0 page, 1 port_reset, 2 port_flush, 3 active, 4 dout
  function automatic logic [31:0] act_val(int s);
    case (s)
      0:       return 32'(bus.page);
      1:       return 32'(bus.port_reset);
      2:       return 32'(bus.port_flush);
      3:       return 32'(bus.active);
      default: return 32'(bus.dout);
    endcase
  endfunction

  always @(negedge clk_sys) begin
    exp_t keep[$];
    logic [31:0] a;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        a = act_val(sb[i].sel);
        if (a !== sb[i].val) begin
          errs++;
          $display("FAIL %s @cyc %0d: got %h want %h",
                   sb[i].name, cyc, a, sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errs++;
        $display("FAIL %s: check for cyc %0d missed",
                 sb[i].name, sb[i].cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic push(int c, string n, int s, logic [31:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic tickn(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d, output int c);
    tick();
    bus.wren = 1'b1;
    bus.A    = a;
    bus.din  = d;
    c = cyc;
    tick();
    bus.wren = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, output int c);
    tick();
    bus.ren = 1'b1;
    bus.A   = a;
    c = cyc;
    tick();
    bus.ren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, c1, r;
    rst = 1'b1;
    bus.wren = 1'b0;
    bus.ren  = 1'b0;
    bus.A    = '0;
    bus.din  = '0;
    bus.port_req   = '0;
    bus.port_ready = '0;
    bus.port_busy  = '0;
    tickn(2);
    push(cyc, "rst_page", 0, 0);
    push(cyc, "rst_active", 3, 0);
    push(cyc, "rst_preset", 1, 0);
    push(cyc, "rst_pflush", 2, 0);
    push(cyc, "rst_dout", 4, 0);
    tick();
    rst = 1'b0;
    tick();

    // plain page swap on port 1
    wr(2'd3, 8'h05, c);
    push(c + 1, "t1_active", 3, 1);
    push(c + 2, "t1_page_old", 0, 0);
    push(c + 3, "t1_page_new", 0, 32'h280);
    push(c + 3, "t1_idle", 3, 0);
    for (int i = 1; i <= 3; i++) begin
      push(c + i, "t1_noflush", 2, 0);
      push(c + i, "t1_noreset", 1, 0);
    end
    tickn(3);

    // drain holds off the swap
    bus.port_req = 2'b10;
    wr(2'd3, 8'h09, c);
    for (int i = 1; i <= 11; i++)
      push(c + i, "t2_hold", 0, 32'h280);
    tickn(10);
    bus.port_ready = 2'b10;
    r = cyc;
    push(r + 1, "t2_pre", 0, 32'h280);
    push(r + 2, "t2_page", 0, 32'h480);
    tickn(2);
    bus.port_req   = '0;
    bus.port_ready = '0;
    tick();

    // AUTO sequence on port 1
    wr(2'd2, 8'h0C, c);
    push(c + 1, "t3_cfg_noact", 3, 0);
    wr(2'd3, 8'h12, c);
    push(c + 1, "t3_fl_pre", 2, 0);
    push(c + 2, "t3_fl_pulse", 2, 32'h2);
    push(c + 3, "t3_fl_end", 2, 0);
    push(c + 4, "t3_page_old", 0, 32'h480);
    push(c + 5, "t3_page_new", 0, 32'h900);
    push(c + 4, "t3_rst_pre", 1, 0);
    push(c + 5, "t3_rst_hi1", 1, 32'h2);
    push(c + 6, "t3_rst_hi2", 1, 32'h2);
    push(c + 7, "t3_rst_lo", 1, 0);
    push(c + 7, "t3_rwait", 3, 1);
    push(c + 8, "t3_idle", 3, 0);
    tickn(8);

    // port 0: disabled write ignored, flush not supported
    wr(2'd0, 8'h03, c);
    push(c + 1, "t4_ignored", 3, 0);
    wr(2'd0, 8'h0B, c);
    push(c + 1, "t4_rst_pre", 1, 0);
    push(c + 2, "t4_rst_hi1", 1, 32'h1);
    push(c + 3, "t4_rst_hi2", 1, 32'h1);
    push(c + 4, "t4_rst_lo", 1, 0);
    for (int i = 1; i <= 4; i++)
      push(c + i, "t4_noflush", 2, 0);
    push(c + 5, "t4_idle", 3, 0);
    tickn(5);

    // page write while in RWAIT is dropped
    bus.port_busy = 2'b01;
    wr(2'd0, 8'h09, c);
    push(c + 2, "t5_rst_hi", 1, 32'h1);
    tickn(4);
    wr(2'd1, 8'h33, c1);
    push(c1 + 3, "t5_page_kept", 0, 32'h900);
    push(c1 + 3, "t5_rwait", 3, 1);
    tickn(3);
    bus.port_busy = '0;
    r = cyc;
    push(r + 1, "t5_idle", 3, 0);
    push(r + 1, "t5_page_same", 0, 32'h900);
    tickn(2);
`ifdef MSC_STATUS_READ_EN
    rd(2'd0, c);
    push(c + 1, "t5_err_set", 4, 32'h04);
    rd(2'd0, c);
    push(c + 1, "t5_err_clr", 4, 0);
    rd(2'd3, c);
    push(c + 1, "t5_page_rd", 4, 32'h12);
`else
    rd(2'd0, c);
    push(c + 1, "t5_dout_zero", 4, 0);
`endif
    tick();

    // async reset during FWAIT
    bus.port_busy = 2'b10;
    wr(2'd3, 8'h21, c);
    push(c + 2, "t6_flush", 2, 32'h2);
    push(c + 3, "t6_fwait", 3, 1);
    tickn(3);
    rst = 1'b1;
    r = cyc;
    push(r, "t6_page0", 0, 0);
    push(r, "t6_active0", 3, 0);
    push(r, "t6_preset0", 1, 0);
    push(r, "t6_pflush0", 2, 0);
    tick();
    rst = 1'b0;
    bus.port_busy = '0;
    tick();
    wr(2'd3, 8'h05, c);
    push(c + 2, "t6_page_old", 0, 0);
    push(c + 3, "t6_page_new", 0, 32'h280);
    for (int i = 1; i <= 3; i++)
      push(c + i, "t6_noflush", 2, 0);
    tickn(4);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks += sb.size();
      errs += sb.size();
      $display("FAIL drain: %0d checks never reached", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
